div_unit: RTL and testbench
===========================

# div_unit

Iterative radix-2 integer divider in the EX stage, beside the ALU, for DIV/DIVU. It takes the same register operands as the ALU and stalls EX while it works. It returns the quotient for LO and the remainder for HI through the same hi/lo write path the multiplier uses. The design has one restoring-division step per cycle, a signed/unsigned front end, and a result hold until the pipeline acknowledges.

## Interface
- DIV_W, 32, operand/result width; only 32 is supported.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  DIV/DIVU present in EX; held high while EX is stalled.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i.
- annul_i  in  1  EX flush or exception in MEM; aborts the operation.
- ack_i  in  1  EX advances this cycle; consumes the result.
- dividend_i  in  32  rs value (reg1).
- divisor_i  in  32  rt value (reg2).
- div_stall_o  out  1  EX must hold.
- done_o  out  1  quotient_o/remainder_o valid.
- quotient_o  out  32  to lo write data.
- remainder_o  out  32  to hi write data.

## Operation
- States: IDLE, BUSY, DONE, in a shared enum.
- **IDLE**
  - start_i & ~annul_i & divisor_i==0 → DONE, with quotient 0xFFFFFFFF and remainder = dividend_i.
  - start_i & ~annul_i & divisor_i!=0 → BUSY. Latch |dividend|, |divisor| (plain values if unsigned), neg_q = signed & (sign_a ^ sign_b), neg_r = signed & sign_a. Clear cnt (6 bit) and the 33-bit partial remainder.
- **BUSY**, each cycle:
  - Shift {rem, quo} left 1 bit.
  - Trial-subtract the divisor from the 33-bit rem. If the result is non-negative, keep it and set the quotient LSB.
  - cnt++. After the step with cnt==31, go to DONE; the sign fix is applied on that same edge to the output registers.
- **Sign fix**
  - Quotient is negated if neg_q; remainder is negated if neg_r.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. Wrap-around is the required result; there is no trap.
- **DONE**
  - done_o = 1; results are held stable.
  - ack_i → IDLE. start_i is ignored in DONE, so a held start cannot restart the same instruction.
- **annul_i** in any state → IDLE on the next edge. Output registers are not updated; no result is produced.
- **div_stall_o** = start_i & ~annul_i & (state==IDLE | state==BUSY). It is combinational, so EX stalls in the start cycle.
- **Reset:** state IDLE, div_stall_o 0, done_o 0, quotient_o 0, remainder_o 0, cnt 0. Reset mid-BUSY discards the operation.

## Timing
- Start accepted at edge E0 (IDLE, start_i high).
- Nonzero divisor:
  - Iterations occur at edges E1..E32.
  - done_o is high from E32; div_stall_o is high from the start cycle until E32.
  - Total 33 EX cycles including the start cycle.
- Divide-by-zero: done_o high after E0; 1 stall cycle.
- ack_i in the first DONE cycle → IDLE at the next edge. A new start_i is accepted at the following edge, so there is a minimum 1-cycle gap between operations.
- annul_i and ack_i in the same cycle: annul wins.
- Outputs change only on clock edges, apart from div_stall_o.

## Structure
- Shared package `div_pkg`: div_state_t {IDLE, BUSY, DONE}, DIV_STEPS = 32, DIV_BY_ZERO_Q = 32'hFFFFFFFF.
- `alu_defines.vh` gains DIV_CONTROL and DIVU_CONTROL. The decode of start_i/signed_i from alucontrol stays in the EX top level.
- One sub-module is natural: `div_step`. It is combinational, one shift/trial-subtract: inputs rem[32:0], quo[31:0], divisor[31:0]; outputs next rem and quo.
- No vendor IP.

## Test plan
- DIVU 100 / 7 → quotient 14, remainder 2; done_o exactly 33 cycles after start; stall low once done.
- DIV −7 / 2 (0xFFFFFFF9, 2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / −2 → quotient 0xFFFFFFFD, remainder 1.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divisor 0, dividend 0x1234 → done_o after 1 edge, quotient 0xFFFFFFFF, remainder 0x1234.
- annul_i at cycle 10 of BUSY → IDLE next edge, done_o never rises, outputs unchanged. Then a new DIVU 9/3 → 3, 0.
- rst_i low at cycle 20 of BUSY → all outputs 0 immediately. start_i held through DONE without ack_i for 5 cycles → no restart. Then ack_i → IDLE.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-2 divider.
// Imported by the divider top level and its per-cycle step logic.
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = 6;

  localparam logic [DIV_W-1:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;
  localparam logic [CNT_W-1:0] LAST_STEP     = CNT_W'(DIV_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  // Magnitude of an operand; unsigned operands pass through untouched.
  function automatic logic [DIV_W-1:0] absVal(input logic [DIV_W-1:0] value,
                                              input logic             isSigned);
    return (isSigned && value[DIV_W-1]) ? (~value + 1'b1) : value;
  endfunction

  function automatic logic [DIV_W-1:0] negIf(input logic [DIV_W-1:0] value,
                                             input logic             doNeg);
    return doNeg ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the divisor,
// and keep the difference (setting the quotient LSB) when it is non-negative.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W:0]   rem_i,
  input  logic [DIV_W-1:0] quo_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic [DIV_W:0]   rem_o,
  output logic [DIV_W-1:0] quo_o
);

  logic [DIV_W+1:0] shiftRem;
  logic [DIV_W+1:0] trialRem;
  logic [DIV_W-1:0] shiftQuo;

  // The extra top bit of the trial result acts as the borrow/sign flag.
  always_comb begin
    shiftRem = {rem_i, quo_i[DIV_W-1]};
    shiftQuo = {quo_i[DIV_W-2:0], 1'b0};
    trialRem = shiftRem - {2'b00, divisor_i};
    rem_o    = shiftRem[DIV_W:0];
    quo_o    = shiftQuo;
    if (!trialRem[DIV_W+1]) begin
      rem_o    = trialRem[DIV_W:0];
      quo_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit for EX: one restoring step per cycle, sign fix on the
// final step, and a held result until the pipeline acknowledges it.
module div_unit
  import div_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic             ack_i,
  input  logic [DIV_W-1:0] dividend_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic             div_stall_o,
  output logic             done_o,
  output logic [DIV_W-1:0] quotient_o,
  output logic [DIV_W-1:0] remainder_o
);

  div_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DIV_W:0]   rem_q;
  logic [DIV_W-1:0] quo_q;
  logic [DIV_W-1:0] divisor_q;
  logic             negQuo_q;
  logic             negRem_q;
  logic             done_q;
  logic [DIV_W-1:0] quotient_q;
  logic [DIV_W-1:0] remainder_q;

  logic [DIV_W:0]   stepRem_d;
  logic [DIV_W-1:0] stepQuo_d;

  div_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (stepRem_d),
    .quo_o     (stepQuo_d)
  );

  // Annul beats everything, including an ack in the same cycle, and leaves
  // the result registers untouched so no partial result ever escapes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      negQuo_q    <= 1'b0;
      negRem_q    <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else if (annul_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (divisor_i == '0) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              quotient_q  <= DIV_BY_ZERO_Q;
              remainder_q <= dividend_i;
            end else begin
              state_q   <= BUSY;
              cnt_q     <= '0;
              rem_q     <= '0;
              quo_q     <= absVal(dividend_i, signed_i);
              divisor_q <= absVal(divisor_i, signed_i);
              negQuo_q  <= signed_i & (dividend_i[DIV_W-1] ^ divisor_i[DIV_W-1]);
              negRem_q  <= signed_i & dividend_i[DIV_W-1];
            end
          end
        end
        BUSY: begin
          rem_q <= stepRem_d;
          quo_q <= stepQuo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            quotient_q  <= negIf(stepQuo_d, negQuo_q);
            remainder_q <= negIf(stepRem_d[DIV_W-1:0], negRem_q);
          end
        end
        DONE: begin
          // A still-asserted start is ignored here so the same instruction never reruns.
          if (ack_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign div_stall_o = start_i & ~annul_i & ((state_q == IDLE) | (state_q == BUSY));
  assign done_o      = done_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver pushes reference results computed
// with plain integer arithmetic, a monitor pops them whenever done_o rises.
module tb_div_unit;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          startCycle;
    int          latency;
    string       name;
  } exp_t;

  exp_t expQueue[$];

  int checks     = 0;
  int failures   = 0;
  int cycleCount = 0;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic        isSignedIn = 1'b0;
  logic        annul = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        divStall;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  logic [31:0] lastQ = '0;
  logic [31:0] lastR = '0;

  div_unit dut (
    .clk_i       (clk),
    .rst_i       (rstN),
    .start_i     (start),
    .signed_i    (isSignedIn),
    .annul_i     (annul),
    .ack_i       (ack),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .div_stall_o (divStall),
    .done_o      (done),
    .quotient_o  (quotient),
    .remainder_o (remainder)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Reference: 64-bit arithmetic sidesteps the INT_MIN / -1 overflow and
  // truncates toward zero, giving the architectural wrap-around result.
  task automatic modelDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'hFFFFFFFF;
      r = a;
    end else if (sgn) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input int holdCycles, input string name);
    exp_t        e;
    logic [31:0] q;
    logic [31:0] r;
    int          waited;
    modelDiv(sgn, a, b, q, r);
    @(posedge clk); #1;
    e.q          = q;
    e.r          = r;
    e.startCycle = cycleCount;
    e.latency    = (b == 32'd0) ? 1 : 33;
    e.name       = name;
    expQueue.push_back(e);
    start      = 1'b1;
    isSignedIn = sgn;
    dividend   = a;
    divisor    = b;
    #1;
    checkOutput({name, "_stall_start"}, 32'(divStall), 32'd1);
    waited = 0;
    while (!done && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!done) begin
      checkOutput({name, "_timeout_done"}, 32'(done), 32'd1);
      start = 1'b0;
      return;
    end
    for (int i = 0; i < holdCycles; i++) begin
      checkOutput({name, "_hold_done"}, 32'(done), 32'd1);
      checkOutput({name, "_hold_q"}, quotient, q);
      checkOutput({name, "_hold_stall"}, 32'(divStall), 32'd0);
      @(posedge clk); #1;
    end
    ack = 1'b1;
    @(posedge clk); #1;
    ack   = 1'b0;
    start = 1'b0;
    checkOutput({name, "_done_after_ack"}, 32'(done), 32'd0);
    lastQ = q;
    lastR = r;
  endtask

  // Monitor: every rising done_o must match the oldest outstanding expectation.
  initial begin
    logic prevDone;
    exp_t e;
    prevDone = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !prevDone) begin
        if (expQueue.size() == 0) begin
          checkOutput("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = expQueue.pop_front();
          checkOutput({e.name, "_quotient"}, quotient, e.q);
          checkOutput({e.name, "_remainder"}, remainder, e.r);
          checkOutput({e.name, "_latency"}, 32'(cycleCount - e.startCycle), 32'(e.latency));
          checkOutput({e.name, "_stall_at_done"}, 32'(divStall), 32'd0);
        end
      end
      prevDone = done;
    end
  end

  initial begin
    logic        sawDone;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;

    #2;
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_stall", 32'(divStall), 32'd0);
    checkOutput("reset_quotient", quotient, 32'd0);
    checkOutput("reset_remainder", remainder, 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;

    applyStimulus(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
    applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, 0, "div_m7_2");
    applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE, 0, "div_7_m2");
    applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, "div_min_m1");
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1, 0, "divu_max_1");
    applyStimulus(1'b1, 32'h00001234, 32'd0, 0, "div_by_zero");

    // Annul in the tenth BUSY cycle: no result, outputs keep the previous one.
    @(posedge clk); #1;
    start      = 1'b1;
    isSignedIn = 1'b0;
    dividend   = 32'd1000;
    divisor    = 32'd3;
    @(posedge clk); #1;
    repeat (9) begin
      @(posedge clk); #1;
    end
    annul = 1'b1;
    #1;
    checkOutput("annul_stall", 32'(divStall), 32'd0);
    @(posedge clk); #1;
    annul   = 1'b0;
    start   = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      sawDone = sawDone | done;
    end
    checkOutput("annul_no_done", 32'(sawDone), 32'd0);
    checkOutput("annul_q_kept", quotient, lastQ);
    checkOutput("annul_r_kept", remainder, lastR);
    applyStimulus(1'b0, 32'd9, 32'd3, 0, "divu_9_3_after_annul");

    // Asynchronous reset in the twentieth BUSY cycle clears everything at once.
    @(posedge clk); #1;
    start      = 1'b1;
    isSignedIn = 1'b1;
    dividend   = 32'hDEADBEEF;
    divisor    = 32'd17;
    @(posedge clk); #1;
    repeat (19) begin
      @(posedge clk); #1;
    end
    rstN  = 1'b0;
    start = 1'b0;
    #1;
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_stall", 32'(divStall), 32'd0);
    checkOutput("midreset_quotient", quotient, 32'd0);
    checkOutput("midreset_remainder", remainder, 32'd0);
    @(posedge clk); #1;
    rstN  = 1'b1;
    lastQ = '0;
    lastR = '0;

    applyStimulus(1'b0, 32'd12345, 32'd100, 5, "divu_hold_no_ack");

    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 7));
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      applyStimulus(sgn, a, b, 0, "random");
    end

    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", 32'(expQueue.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
